// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states and default bus widths.
// Imported by both requester-side and slave-side blocks.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_master_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB bus seen by the requester.
// The master modport is the requester; slave is its environment.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  cmd_valid, cmd_write,
    input  cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output paddr, psel, penable,
    output pwrite, pwdata,
    input  prdata, pready
  );

  modport slave (
    output cmd_valid, cmd_write,
    output cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  paddr, psel, penable,
    input  pwrite, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one command in, one SETUP/ACCESS
// transfer out, one response back, with a bounded wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  apb_master_if.master bus
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  apb_master_state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pwrite_q, pwrite_d;
  logic              err_q, err_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rvalid_q, rvalid_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_write ?
                     bus.cmd_wdata : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // completion beats timeout on the last cycle
        if (bus.pready) begin
          rdata_d = pwrite_q ? '0 : bus.prdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
    endcase
    psel_d    = (state_d == SETUP) ||
                (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    rvalid_d  = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rvalid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small wait-state APB slave.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_apb_master;

  logic clk;
  logic rst_n;

  int errors;
  int checks;

  int ws;
  bit hang;
  int acc_cnt;
  logic [31:0] mem [0:63];

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_cnt <= 0;
    else if (bus.psel && bus.penable && !bus.pready)
      acc_cnt <= acc_cnt + 1;
    else
      acc_cnt <= 0;
  end

  assign bus.pready = !hang && bus.psel &&
                      bus.penable && (acc_cnt >= ws);
  assign bus.prdata = mem[bus.paddr[7:2]];

  always @(posedge clk) begin
    if (bus.psel && bus.penable &&
        bus.pready && bus.pwrite)
      mem[bus.paddr[7:2]] <= bus.pwdata;
  end

  task automatic send(input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d);
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 ||
        bus.pwrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_apb: psel=%b penable=%b pwrite=%b want 000",
               bus.psel, bus.penable, bus.pwrite);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
        bus.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b err=%b rdata=%h want 0 0 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    checks++;
    if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 ||
        bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_regs: paddr=%h pwdata=%h ready=%b want 0 0 1",
               bus.paddr, bus.pwdata, bus.cmd_ready);
    end
  endtask

  task automatic test_write_zero_ws;
    ws = 0;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready: got %b want 1", bus.cmd_ready);
    end
    send(1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b0 ||
        bus.pwrite !== 1'b1 || bus.paddr !== 32'h10 ||
        bus.pwdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_setup: sel=%b en=%b wr=%b a=%h d=%h want 1 0 1 10 deadbeef",
               bus.psel, bus.penable, bus.pwrite,
               bus.paddr, bus.pwdata);
    end
    @(negedge clk);
    checks++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b1 ||
        bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_access: sel=%b en=%b rv=%b want 1 1 0",
               bus.psel, bus.penable, bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 ||
        bus.rsp_rdata !== 32'h0 || bus.psel !== 1'b0 ||
        bus.penable !== 1'b0) begin
      errors++;
      $display("FAIL wr_resp: rv=%b err=%b rd=%h sel=%b en=%b want 1 0 0 0 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata,
               bus.psel, bus.penable);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_done: rv=%b ready=%b want 0 1",
               bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_read_ws2;
    int n;
    ws = 2;
    send(1'b0, 32'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (bus.psel !== 1'b1 || bus.pwrite !== 1'b0 ||
        bus.pwdata !== 32'h0) begin
      errors++;
      $display("FAIL rd_setup: sel=%b wr=%b d=%h want 1 0 0",
               bus.psel, bus.pwrite, bus.pwdata);
    end
    n = 0;
    @(negedge clk);
    while (bus.psel && bus.penable && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL rd_ws2_len: access cycles %0d want 3", n);
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 ||
        bus.rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_ws2_rsp: rv=%b err=%b rd=%h want 1 0 deadbeef",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    hang = 1'b1;
    send(1'b0, 32'h20, 32'h0);
    @(negedge clk);
    n = 0;
    @(negedge clk);
    while (bus.psel && bus.penable && n < 40) begin
      n++;
      @(negedge clk);
    end
    hang = 1'b0;
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL tmo_len: access cycles %0d want 16", n);
    end
    checks++;
    if (bus.psel !== 1'b0 || bus.rsp_valid !== 1'b1 ||
        bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL tmo_rsp: sel=%b rv=%b err=%b rd=%h want 0 1 1 0",
               bus.psel, bus.rsp_valid, bus.rsp_err,
               bus.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int bad;
    ws = 0;
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: rv=%b want 1", bus.rsp_valid);
    end
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h40;
    bus.cmd_wdata = 32'h5555_5555;
    bus.cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 ||
          bus.rsp_rdata !== 32'hDEADBEEF ||
          bus.rsp_err !== 1'b0 ||
          bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles want 0 (rv=%b rd=%h rdy=%b sel=%b)",
               bad, bus.rsp_valid, bus.rsp_rdata,
               bus.cmd_ready, bus.psel);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rv=%b ready=%b want 0 1",
               bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_mid;
    int spur;
    hang = 1'b1;
    send(1'b0, 32'h10, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 ||
        bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: sel=%b en=%b rv=%b rdy=%b want 0 0 0 1",
               bus.psel, bus.penable, bus.rsp_valid,
               bus.cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    spur = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.psel) spur++;
    end
    checks++;
    if (spur != 0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: spurious=%0d rdy=%b want 0 1",
               spur, bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addr_t [3];
    logic [31:0] data_t [3];
    int acc [3];
    int k, nrsp, badrsp, low, gaps, badgap;
    bit prev_acc, prev_sel, seen;
    addr_t = '{32'h0, 32'h4, 32'h8};
    data_t = '{32'h1111_1111, 32'h2222_2222,
               32'h3333_3333};
    acc = '{-1, -1, -1};
    ws = 0;
    bus.rsp_ready = 1'b1;
    k = 0; nrsp = 0; badrsp = 0;
    low = 0; gaps = 0; badgap = 0;
    prev_acc = 1'b0; prev_sel = 1'b0; seen = 1'b0;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = addr_t[0];
    bus.cmd_wdata = data_t[0];
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (prev_acc) begin
        if (k < 3) begin
          bus.cmd_addr  = addr_t[k];
          bus.cmd_wdata = data_t[k];
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      prev_acc = bus.cmd_valid && bus.cmd_ready;
      if (prev_acc && k < 3) begin
        acc[k] = i;
        k++;
      end
      if (bus.psel) begin
        if (seen && !prev_sel) begin
          gaps++;
          if (low != 2) badgap++;
        end
        seen = 1'b1;
        low = 0;
      end else begin
        low++;
      end
      prev_sel = bus.psel;
      if (bus.rsp_valid) begin
        nrsp++;
        if (bus.rsp_err !== 1'b0 ||
            bus.rsp_rdata !== 32'h0)
          badrsp++;
      end
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
      errors++;
      $display("FAIL b2b_accept: at %0d %0d %0d want 4 apart",
               acc[0], acc[1], acc[2]);
    end
    checks++;
    if (gaps != 2 || badgap != 0) begin
      errors++;
      $display("FAIL b2b_gap: gaps=%0d bad=%0d want 2 0",
               gaps, badgap);
    end
    checks++;
    if (nrsp != 3 || badrsp != 0) begin
      errors++;
      $display("FAIL b2b_rsp: rsp=%0d bad=%0d want 3 0",
               nrsp, badrsp);
    end
    checks++;
    if (mem[0] !== 32'h1111_1111 ||
        mem[1] !== 32'h2222_2222 ||
        mem[2] !== 32'h3333_3333) begin
      errors++;
      $display("FAIL b2b_mem: %h %h %h want 11111111 22222222 33333333",
               mem[0], mem[1], mem[2]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ws = 0;
    hang = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_write_zero_ws();
    test_read_ws2();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
